// File: rtl/cactus_pkg.sv
// Shared state and obstacle-kind definitions for the cactus spawner.
// Define CACTUS_BIRD_EN to let mix value 3 produce the bird kind.
package cactus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GAP,
    OFFER
  } state_t;

  localparam logic [1:0] KIND_SMALL  = 2'd0;
  localparam logic [1:0] KIND_TALL   = 2'd1;
  localparam logic [1:0] KIND_DOUBLE = 2'd2;
  localparam logic [1:0] KIND_BIRD   = 2'd3;

  function automatic logic [1:0] map_kind(
    input logic [1:0] sel
  );
`ifdef CACTUS_BIRD_EN
    return sel;
`else
    // Without birds the top code folds onto the double cactus.
    return (sel == KIND_BIRD) ? KIND_DOUBLE : sel;
`endif
  endfunction

endpackage

// File: rtl/spawn_gap_timer.sv
// Loadable tick-driven down-counter for the spawn gap.
// expire flags the tick that takes the count from 1 to 0.
module spawn_gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  input  logic             en,
  input  logic             tick,
  output logic [GAP_W-1:0] count,
  output logic             expire
);

  localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

  logic step;

  assign step   = run && en && tick && (count != '0);
  assign expire = step && (count == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (step) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/cactus_spawner.sv
// Paces random obstacle spawn offers over a valid/ready handshake.
// Kind 3 (bird) is produced only when CACTUS_BIRD_EN is defined.
module cactus_spawner
  import cactus_pkg::*;
#(
  parameter int MIN_GAP   = 40,
  parameter int GAP_SHIFT = 1,
  parameter int GAP_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             tick,
  input  logic [4:0]       random,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [1:0]       spawn_kind,
  output logic [7:0]       spawn_count,
  output logic [GAP_W-1:0] gap_remaining
);

  state_t           state;
  logic [4:0]       mix;
  logic [GAP_W-1:0] mix_w;
  logic [GAP_W-1:0] gap_load;
  logic             load;
  logic             timer_en;
  logic             expire;
  logic             accept;

  // XOR with the count keeps back-to-back spawns varied.
  assign mix      = random ^ spawn_count[4:0];
  assign mix_w    = GAP_W'(mix);
  assign gap_load = GAP_W'(MIN_GAP) + (mix_w << GAP_SHIFT);
  assign load     = run && (state == LOAD);
  assign timer_en = (state == GAP);
  assign accept   = spawn_valid && spawn_ready;

  spawn_gap_timer #(
    .GAP_W(GAP_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .load  (load),
    .value (gap_load),
    .en    (timer_en),
    .tick  (tick),
    .count (gap_remaining),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      spawn_valid <= 1'b0;
      spawn_kind  <= KIND_SMALL;
      spawn_count <= 8'd0;
    end else if (!run) begin
      // A handshake on the falling edge of run still counts.
      if (accept) begin
        spawn_count <= spawn_count + 8'd1;
      end
      state       <= IDLE;
      spawn_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= LOAD;
        end
        LOAD: begin
          spawn_kind <= map_kind(mix[1:0]);
          state      <= GAP;
        end
        GAP: begin
          if (expire) begin
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            spawn_count <= spawn_count + 8'd1;
            spawn_valid <= 1'b0;
            state       <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cactus_spawner.sv
// Scoreboard bench for cactus_spawner: directed scenarios, then
// randomized traffic against a rule-level reference model.
module tb_cactus_spawner;
  import cactus_pkg::*;

  localparam int MIN_GAP   = 40;
  localparam int GAP_SHIFT = 1;
  localparam int GAP_W     = 8;
`ifdef CACTUS_BIRD_EN
  localparam int K3 = KIND_BIRD;
`else
  localparam int K3 = KIND_DOUBLE;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             tick;
  logic [4:0]       random;
  logic             spawn_valid;
  logic             spawn_ready;
  logic [1:0]       spawn_kind;
  logic [7:0]       spawn_count;
  logic [GAP_W-1:0] gap_remaining;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cactus_spawner #(
    .MIN_GAP  (MIN_GAP),
    .GAP_SHIFT(GAP_SHIFT),
    .GAP_W    (GAP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .tick         (tick),
    .random       (random),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_kind   (spawn_kind),
    .spawn_count  (spawn_count),
    .gap_remaining(gap_remaining)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic int exp_gap(input int r, input int c);
    int m;
    m = (r ^ c) & 31;
    return (MIN_GAP + (m << GAP_SHIFT)) % (1 << GAP_W);
  endfunction

  function automatic int exp_kind(input int r, input int c);
    int m;
    m = (r ^ c) & 3;
    return (m == 3) ? K3 : m;
  endfunction

  // Reference model: one spawn is a load, a gap of G ticks, then an offer.
  int m_count = 0;
  int m_left  = 0;
  bit m_on    = 1'b0;
  bit m_load  = 1'b0;
  bit m_offer = 1'b0;
  int kq[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_count = 0; m_left = 0;
        m_on = 0; m_load = 0; m_offer = 0;
        kq.delete();
      end else if (!run) begin
        if (m_offer && spawn_ready) m_count = (m_count + 1) % 256;
        m_on = 0; m_load = 0; m_offer = 0; m_left = 0;
        kq.delete();
      end else if (!m_on) begin
        m_on = 1; m_load = 1;
      end else if (m_load) begin
        m_left = exp_gap(int'(random), m_count);
        kq.push_back(exp_kind(int'(random), m_count));
        m_load = 0;
      end else if (m_offer) begin
        if (spawn_ready) begin
          m_count = (m_count + 1) % 256;
          m_offer = 0; m_load = 1;
        end
      end else if (tick) begin
        m_left--;
        if (m_left == 0) m_offer = 1;
      end
    end
  end

  // Monitor: compares every cycle and pops a kind on each offer.
  initial begin
    logic pv;
    int   cur_kind;
    pv = 1'b0;
    cur_kind = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("sb_valid", int'(spawn_valid), int'(m_offer));
        check("sb_count", int'(spawn_count), m_count);
        check("sb_gap", int'(gap_remaining), m_left);
        if (spawn_valid && !pv) begin
          check("sb_queued", kq.size(), 1);
          if (kq.size() > 0) cur_kind = kq.pop_front();
        end
        if (spawn_valid) check("sb_kind", int'(spawn_kind), cur_kind);
        pv = spawn_valid;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e;
    rst = 1'b1; run = 1'b0; tick = 1'b0;
    random = 5'd0; spawn_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst_valid", int'(spawn_valid), 0);
    check("rst_kind", int'(spawn_kind), 0);
    check("rst_count", int'(spawn_count), 0);
    check("rst_gap", int'(gap_remaining), 0);

    // Basic spawn
    random = 5'd3; tick = 1'b1; spawn_ready = 1'b1; run = 1'b1;
    cyc(1);
    check("basic_load_gap", int'(gap_remaining), 0);
    cyc(1);
    check("basic_gap", int'(gap_remaining), 46);
    e = 2;
    while (!spawn_valid && e < 200) begin cyc(1); e++; end
    check("basic_rise_edge", e, 48);
    check("basic_kind", int'(spawn_kind), K3);
    cyc(1);
    check("basic_count", int'(spawn_count), 1);
    check("basic_drop", int'(spawn_valid), 0);

    // Second spawn, then backpressure
    cyc(1);
    check("second_gap", int'(gap_remaining), 44);
    spawn_ready = 1'b0;
    e = 50;
    while (!spawn_valid && e < 200) begin cyc(1); e++; end
    check("second_rise_edge", e, 94);
    check("second_kind", int'(spawn_kind), 2);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bp_valid", int'(spawn_valid), 1);
      check("bp_kind", int'(spawn_kind), 2);
      check("bp_count", int'(spawn_count), 1);
      check("bp_gap", int'(gap_remaining), 0);
    end
    spawn_ready = 1'b1;
    cyc(1);
    check("bp_accept_count", int'(spawn_count), 2);
    check("bp_accept_valid", int'(spawn_valid), 0);
    cyc(1);
    check("bp_single", int'(spawn_count), 2);

    // Maximum gap with a tick every 4th cycle
    rst = 1'b1; run = 1'b0;
    cyc(1);
    rst = 1'b0; random = 5'd31; spawn_ready = 1'b1; run = 1'b1;
    e = 0;
    while (!spawn_valid && e < 600) begin
      tick = (e + 1 > 2) && ((e - 1) % 4 == 0);
      cyc(1);
      e++;
      if (e == 2) check("max_gap", int'(gap_remaining), 102);
    end
    check("max_rise_after_gap", e - 2, 408);
    check("max_kind", int'(spawn_kind), K3);
    tick = 1'b1; random = 5'd7;
    cyc(1);
    check("max_count", int'(spawn_count), 1);

    // Run drop mid-gap
    e = 0;
    while (gap_remaining != 20 && e < 200) begin cyc(1); e++; end
    check("drop_reach", int'(gap_remaining), 20);
    run = 1'b0;
    cyc(1);
    check("drop_gap", int'(gap_remaining), 0);
    check("drop_valid", int'(spawn_valid), 0);
    check("drop_count", int'(spawn_count), 1);
    cyc(2);
    check("drop_hold_gap", int'(gap_remaining), 0);
    random = 5'd10; run = 1'b1;
    cyc(2);
    check("reload_gap", int'(gap_remaining), 40 + ((10 ^ 1) << 1));

    // Reset while offering
    spawn_ready = 1'b0;
    e = 0;
    while (!spawn_valid && e < 200) begin cyc(1); e++; end
    check("ro_valid", int'(spawn_valid), 1);
    check("ro_kind", int'(spawn_kind), K3);
    #2 rst = 1'b1;
    #1;
    check("ro_rst_valid", int'(spawn_valid), 0);
    check("ro_rst_kind", int'(spawn_kind), 0);
    check("ro_rst_count", int'(spawn_count), 0);
    check("ro_rst_gap", int'(gap_remaining), 0);
    run = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("ro_idle_valid", int'(spawn_valid), 0);
    check("ro_idle_gap", int'(gap_remaining), 0);

    // Randomized traffic
    run = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      random = 5'($urandom);
      tick = ($urandom_range(3) != 0);
      spawn_ready = 1'($urandom_range(1));
      if ($urandom_range(299) == 0) run = 1'b0;
      else if (!run) run = ($urandom_range(3) == 0);
      cyc(1);
    end
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
